// File: rtl/cpu_control_unit.sv
// Multi-cycle accumulator CPU control unit driving a 16x8 word memory with a combinational read port.
// 3 cycles per direct or register-reference instruction, 4 per indirect; no backpressure, memory never stalls.
module cpu_control_unit #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] mem_address,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] ac,
    output logic       e,
    output logic [3:0] pc,
    output logic       halted
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_INDIRECT = 3'd2;
    localparam logic [2:0] S_EXECUTE  = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_BUN = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_BZ  = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    logic [2:0] state;
    logic [7:0] ir;
    logic [3:0] ar;
    logic [2:0] opcode;
    logic       operand_read;
    logic [8:0] sum_add;
    logic [8:0] sum_sub;
    logic [8:0] sum_inc;

    assign opcode = ir[6:4];

    always_comb begin
        operand_read = (opcode == OP_ADD) || (opcode == OP_AND) ||
                       (opcode == OP_LDA) || (opcode == OP_SUB);
        sum_add = {1'b0, ac} + {1'b0, mem_rdata};
        sum_sub = {1'b0, ac} + {1'b0, ~mem_rdata} + 9'd1;
        sum_inc = {1'b0, ac} + 9'd1;
    end

    // Strobes are gated by reset so the memory is never touched while reset is held.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = ar;
        mem_wdata   = ac;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read    = 1'b1;
                    mem_address = pc;
                end
                S_INDIRECT: mem_read = 1'b1;
                S_EXECUTE: begin
                    mem_read  = operand_read;
                    mem_write = (opcode == OP_STA);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ac     <= 8'h00;
            e      <= 1'b0;
            ir     <= 8'h00;
            ar     <= 4'h0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 4'd1;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ar    <= ir[3:0];
                    state <= (ir[7] && (opcode != OP_REG)) ? S_INDIRECT : S_EXECUTE;
                end
                S_INDIRECT: begin
                    ar    <= mem_rdata[3:0];
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_ADD: {e, ac} <= sum_add;
                        OP_AND: ac <= ac & mem_rdata;
                        OP_STA: ;
                        OP_BUN: pc <= ar;
                        OP_LDA: ac <= mem_rdata;
                        OP_SUB: {e, ac} <= sum_sub;
                        OP_BZ:  if (ac == 8'h00) pc <= ar;
                        default: begin
                            // Register-reference group; unlisted micro-ops fall through as NOP.
                            case (ir[3:0])
                                4'h1: ac <= 8'h00;
                                4'h2: ac <= ~ac;
                                4'h3: {e, ac} <= sum_inc;
                                4'h4: e <= 1'b0;
                                4'hF: begin
                                    state  <= S_HALT;
                                    halted <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a 16x8 combinational-read memory model.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] mem_address;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] ac;
    logic       e;
    logic [3:0] pc;
    logic       halted;

    logic [7:0] mem  [16];
    logic [7:0] prog [16];
    logic       load = 1'b0;

    int vectors = 0;
    int fails   = 0;
    int wcount;
    int strobes;

    cpu_control_unit #(.RESET_PC(4'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .ac          (ac),
        .e           (e),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= prog[i];
        end else if (mem_write) begin
            mem[mem_address] <= mem_wdata;
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Loads prog into memory under reset, checks the reset-cycle strobes, then releases reset.
    task automatic start_run();
        load  = 1'b1;
        reset = 1'b1;
        step(1);
        load = 1'b0;
        check("rst_read",  {7'd0, mem_read},  8'h00);
        check("rst_write", {7'd0, mem_write}, 8'h00);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Run 1: reset release, indirect LDA then direct ADD
        clear_prog();
        prog[0] = 8'hCC; prog[1] = 8'h0A; prog[9] = 8'h08;
        prog[10] = 8'h02; prog[12] = 8'h09;
        start_run();
        check("fetch0_read", {7'd0, mem_read}, 8'h01);
        check("fetch0_addr", {4'd0, mem_address}, 8'h00);
        check("reset_ac", ac, 8'h00);
        check("reset_e", {7'd0, e}, 8'h00);
        check("reset_pc", {4'd0, pc}, 8'h00);
        check("reset_halted", {7'd0, halted}, 8'h00);
        step(3);
        check("ind_exec_ac", ac, 8'h00);
        check("ind_exec_addr", {4'd0, mem_address}, 8'h09);
        step(1);
        check("ind_lda_ac", ac, 8'h08);
        check("ind_lda_pc", {4'd0, pc}, 8'h01);
        step(3);
        check("add_ac", ac, 8'h0A);
        check("add_pc", {4'd0, pc}, 8'h02);

        // Run 2: STA single write, read-back, HLT freeze, reset out of HALT
        clear_prog();
        prog[0] = 8'h4D; prog[13] = 8'h05; prog[1] = 8'h2E;
        prog[2] = 8'h71; prog[3] = 8'h4E; prog[4] = 8'h7F;
        start_run();
        step(3);
        check("lda5_ac", ac, 8'h05);
        wcount = 0;
        wcount += int'(mem_write);
        step(1);
        wcount += int'(mem_write);
        step(1);
        check("sta_write", {7'd0, mem_write}, 8'h01);
        check("sta_addr", {4'd0, mem_address}, 8'h0E);
        check("sta_wdata", mem_wdata, 8'h05);
        check("sta_no_read", {7'd0, mem_read}, 8'h00);
        wcount += int'(mem_write);
        step(1);
        wcount += int'(mem_write);
        check("sta_write_count", wcount[7:0], 8'h01);
        check("mem_e", mem[14], 8'h05);
        step(3);
        check("cla_ac", ac, 8'h00);
        step(3);
        check("lda_e_ac", ac, 8'h05);
        step(3);
        check("hlt_halted", {7'd0, halted}, 8'h01);
        check("hlt_pc", {4'd0, pc}, 8'h05);
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            strobes += int'(mem_read) + int'(mem_write);
        end
        check("halt_strobes", strobes[7:0], 8'h00);
        check("halt_pc", {4'd0, pc}, 8'h05);
        check("halt_ac", ac, 8'h05);
        check("halt_still", {7'd0, halted}, 8'h01);
        reset = 1'b1;
        step(1);
        check("halt_rst_halted", {7'd0, halted}, 8'h00);
        check("halt_rst_pc", {4'd0, pc}, 8'h00);

        // Run 3: ADD carry, SUB without borrow, BZ taken
        clear_prog();
        prog[0] = 8'h48; prog[8] = 8'hFF; prog[1] = 8'h09; prog[9] = 8'h02;
        prog[2] = 8'h5A; prog[10] = 8'h01; prog[3] = 8'h63;
        start_run();
        step(3);
        check("ldaff_ac", ac, 8'hFF);
        check("ldaff_e", {7'd0, e}, 8'h00);
        step(3);
        check("addc_ac", ac, 8'h01);
        check("addc_e", {7'd0, e}, 8'h01);
        step(3);
        check("sub_ac", ac, 8'h00);
        check("sub_e", {7'd0, e}, 8'h01);
        step(3);
        check("bz_taken_pc", {4'd0, pc}, 8'h03);

        // Run 4: register-reference ops, BZ not taken, AND, BUN, pc wrap via NOP at F
        clear_prog();
        prog[0] = 8'h72; prog[1] = 8'h73; prog[2] = 8'h74; prog[3] = 8'h66;
        prog[6] = 8'h73; prog[7] = 8'h60; prog[8] = 8'h72; prog[9] = 8'h1D;
        prog[13] = 8'h3C; prog[10] = 8'h3F; prog[15] = 8'h70;
        start_run();
        step(3);
        check("cma_ac", ac, 8'hFF);
        step(3);
        check("inc_ac", ac, 8'h00);
        check("inc_e", {7'd0, e}, 8'h01);
        step(3);
        check("cle_e", {7'd0, e}, 8'h00);
        step(3);
        check("bz6_pc", {4'd0, pc}, 8'h06);
        step(3);
        check("inc1_ac", ac, 8'h01);
        step(3);
        check("bz_not_taken_pc", {4'd0, pc}, 8'h08);
        step(3);
        check("cma2_ac", ac, 8'hFE);
        step(3);
        check("and_ac", ac, 8'h3C);
        check("and_e", {7'd0, e}, 8'h00);
        step(3);
        check("bun_pc", {4'd0, pc}, 8'h0F);
        step(3);
        check("wrap_pc", {4'd0, pc}, 8'h00);
        check("wrap_read", {7'd0, mem_read}, 8'h01);
        check("wrap_addr", {4'd0, mem_address}, 8'h00);

        // Run 5: reset in the middle of an indirect ADD, then rerun to completion
        clear_prog();
        prog[0] = 8'h48; prog[8] = 8'h33; prog[1] = 8'h8C;
        prog[12] = 8'h09; prog[9] = 8'h11;
        start_run();
        step(3);
        check("lda33_ac", ac, 8'h33);
        step(2);
        check("indir_read", {7'd0, mem_read}, 8'h01);
        check("indir_addr", {4'd0, mem_address}, 8'h0C);
        reset = 1'b1;
        step(1);
        check("midrst_pc", {4'd0, pc}, 8'h00);
        check("midrst_ac", ac, 8'h00);
        check("midrst_read", {7'd0, mem_read}, 8'h00);
        reset = 1'b0;
        #1;
        check("midrst_fetch_read", {7'd0, mem_read}, 8'h01);
        check("midrst_fetch_addr", {4'd0, mem_address}, 8'h00);
        step(3);
        step(4);
        check("ind_add_ac", ac, 8'h44);
        check("ind_add_pc", {4'd0, pc}, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter: RESET_PC, 4'h0, program counter value loaded on reset.
REQ-002 Port: clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1, synchronous and active-high.
REQ-004 Port: mem_address, output, 4, word address to the 16x8 memory.
REQ-005 Port: mem_read, output, 1, read strobe; memory data is valid combinationally in the same cycle.
REQ-006 Port: mem_write, output, 1, write strobe.
REQ-007 Port: mem_wdata, output, 8, write data driven to the memory data_in.
REQ-008 Port: mem_rdata, input, 8, read data taken from the memory data_out.
REQ-009 Ports: ac (output, 8, accumulator), e (output, 1, carry), pc (output, 4, program counter), halted (output, 1, high in HALT).

Function
REQ-010 Instruction format SHALL be bit7 I (indirect), bits6:4 opcode, bits3:0 address/micro-op.
REQ-011 Opcodes SHALL be: 000 ADD, 001 AND, 010 STA, 011 BUN, 100 LDA, 101 SUB, 110 BZ, 111 register-reference with I ignored.
REQ-012 Register-reference micro-ops (bits3:0) SHALL be: 0000 NOP, 0001 CLA, 0010 CMA, 0011 INC, 0100 CLE, 1111 HLT; other codes act as NOP.
REQ-013 States SHALL be FETCH, DECODE, INDIRECT, EXECUTE, HALT.
REQ-014 FETCH: mem_address=pc, mem_read=1; IR<=mem_rdata, pc<=pc+1 modulo 16 (15 wraps to 0); next state DECODE.
REQ-015 DECODE: AR<=IR[3:0]; next INDIRECT if I=1 and opcode!=111, else EXECUTE; no memory strobe.
REQ-016 INDIRECT: mem_address=AR, mem_read=1, AR<=mem_rdata[3:0]; next EXECUTE.
REQ-017 EXECUTE for ADD/AND/LDA/SUB SHALL assert mem_read at AR and update ac in the same cycle.
REQ-018 ADD SHALL set {e,ac}<=ac+M (9-bit sum); SUB SHALL set {e,ac}<=ac+~M+1, so e=1 means no borrow; AND and LDA SHALL leave e unchanged.
REQ-019 STA SHALL assert mem_write for exactly one cycle with mem_address=AR and mem_wdata=ac.
REQ-020 BUN SHALL set pc<=AR; BZ SHALL set pc<=AR only when ac==0.
REQ-021 Register-reference ops SHALL be: CLA ac<=0; CMA ac<=~ac; INC {e,ac}<=ac+1; CLE e<=0.
REQ-022 HLT SHALL enter HALT; every other EXECUTE returns to FETCH.
REQ-023 Latency SHALL be 3 cycles per direct or register-reference instruction and 4 cycles per indirect instruction.
REQ-024 mem_read and mem_write SHALL never be high together; both SHALL be 0 in DECODE and HALT.
REQ-025 mem_address SHALL be driven to AR when no strobe is active; mem_wdata SHALL always equal ac.
REQ-026 HALT SHALL hold halted=1 and freeze pc, ac and e until reset.

Reset
REQ-027 reset SHALL override all other activity in every state, including mid-instruction and HALT.
REQ-028 On reset: state<=FETCH, pc<=RESET_PC, ac<=0, e<=0, IR<=0, AR<=0, halted<=0.
REQ-029 In the cycle reset is high, mem_read and mem_write SHALL both be 0.
REQ-030 The first FETCH SHALL occur in the first cycle after reset deasserts.

Verification
REQ-031 Reset release -> next cycle mem_read=1 with mem_address=0; ac=0, e=0, pc=0, halted=0.
REQ-032 Memory M0=CC, M1=0A, M9=08, MA=02, MC=09 -> after 4 cycles ac=08 (indirect path, read at C then at 9); after 3 more cycles ac=0A, pc=2.
REQ-033 ac=05 and STA E (0x2E) -> exactly one cycle with mem_write=1, mem_address=E, mem_wdata=05; a following read of E returns 05.
REQ-034 ac=FF and ADD of a word holding 02 -> ac=01, e=1; then SUB of a word holding 01 -> ac=00, e=1; then BZ 3 -> pc=3.
REQ-035 NOP (0x70) at address F -> pc wraps to 0 and the next fetch reads address 0.
REQ-036 HLT (0x7F) -> halted=1, no memory strobes for 10+ cycles, pc frozen; reset asserted during INDIRECT of a later run -> state FETCH, pc=0, ac=0.
